// File: rtl/div_iter_if.sv
// Handshake bundle between the EX stage and the iterative divider.
// The EX stage drives the request side; the divider drives stall/ready/result.
interface div_iter_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic                   signed_div;
    logic                   annul;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   stall_req;
    logic                   ready;
    logic [2*WIDTH-1:0]     result;

    modport master (
        output start, signed_div, annul, a, b,
        input  stall_req, ready, result
    );

    modport slave (
        input  start, signed_div, annul, a, b,
        output stall_req, ready, result
    );
endinterface

// File: rtl/div_iter_unit.sv
// Radix-2 restoring divider: one quotient bit per cycle on operand magnitudes,
// sign fix-up applied when the result is presented as {remainder, quotient}.
//
// state | meaning
// IDLE  | waiting for start & ~annul; operands latched on acceptance
// DIVZ  | divisor was zero; result is forced to 0/0
// ON    | one restoring step per cycle, counter 0..WIDTH-1
// END   | ready pulse, result presented and captured
module div_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    div_iter_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIVZ = 2'd1;
    localparam logic [1:0] S_ON   = 2'd2;
    localparam logic [1:0] S_END  = 2'd3;

    logic [1:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_dvd;
    logic [WIDTH-1:0]     r_dvs;
    logic [WIDTH-1:0]     r_rem;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [2*WIDTH-1:0]   r_result;

    logic                 w_accept;
    logic                 w_done;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH:0]       w_shift;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_diff;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_remd;

    assign w_accept = (r_state == S_IDLE) & bus.start & ~bus.annul;
    assign w_done   = (r_state == S_END) & ~bus.annul;

    assign w_a_mag  = (bus.signed_div & bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign w_b_mag  = (bus.signed_div & bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // The partial remainder stays below the divisor, so the difference fits WIDTH bits.
    assign w_shift  = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge     = (w_shift >= {1'b0, r_dvs});
    assign w_diff   = w_shift[WIDTH-1:0] - r_dvs;

    assign w_quot   = r_neg_q ? -r_dvd : r_dvd;
    assign w_remd   = r_neg_r ? -r_rem : r_rem;

    assign bus.stall_req = w_accept | (r_state == S_DIVZ) | (r_state == S_ON);
    assign bus.ready     = w_done;
    assign bus.result    = w_done ? {w_remd, w_quot} : r_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_neg_q <= bus.signed_div & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        r_neg_r <= bus.signed_div & bus.a[WIDTH-1];
                        r_dvs   <= w_b_mag;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        if (bus.b == '0) begin
                            r_dvd   <= '0;
                            r_state <= S_DIVZ;
                        end else begin
                            r_dvd   <= w_a_mag;
                            r_state <= S_ON;
                        end
                    end
                end
                S_DIVZ: begin
                    r_state <= bus.annul ? S_IDLE : S_END;
                end
                S_ON: begin
                    if (bus.annul) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
                        r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(WIDTH-1))
                            r_state <= S_END;
                    end
                end
                S_END: begin
                    if (!bus.annul)
                        r_result <= {w_remd, w_quot};
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit: directed corner cases plus random
// divides checked against a plain-arithmetic reference model.
module tb_div_iter_unit;
    logic clk;
    logic rst;
    int checks;
    int failures;
    logic [63:0] last_res;

    div_iter_if #(.WIDTH(32)) bus();

    div_iter_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (!sgn) return {a % b, a / b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Drives one request with start held until ready, scrambles operands after
    // acceptance, and records what the DUT did over a fixed 41-cycle window.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output int rdy_cyc, output int rdy_cnt, output int stall_hi,
                          output logic [63:0] res, output logic [63:0] res_after);
        rdy_cyc = -1;
        rdy_cnt = 0;
        stall_hi = 0;
        res = '0;
        bus.annul = 1'b0;
        bus.start = 1'b1;
        bus.signed_div = sgn;
        bus.a = a;
        bus.b = b;
        for (int c = 0; c <= 40; c++) begin
            #1;
            if (bus.stall_req) stall_hi++;
            if (bus.ready) begin
                rdy_cnt++;
                if (rdy_cyc < 0) begin
                    rdy_cyc = c;
                    res = bus.result;
                end
            end
            @(posedge clk);
            #1;
            if (c == 0) begin
                bus.a = $urandom;
                bus.b = $urandom;
                bus.signed_div = ~sgn;
            end
            if (rdy_cyc >= 0) bus.start = 1'b0;
        end
        #1;
        res_after = bus.result;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (bus.ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
        checks++;
        if (bus.stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall_req); end
        checks++;
        if (bus.result !== 64'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.result); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        last_res = 64'd0;
    endtask

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    task automatic test_directed();
        vec_t v[8];
        int rc, rn, sh, lat;
        logic [63:0] r, ra;
        v[0] = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E};
        v[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD};
        v[2] = '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD};
        v[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000};
        v[4] = '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF};
        v[5] = '{1'b0, 32'd5,          32'd0,          64'h00000000_00000000};
        v[6] = '{1'b1, 32'hFFFFFFFB,   32'd0,          64'h00000000_00000000};
        v[7] = '{1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC};
        for (int i = 0; i < 8; i++) begin
            lat = (v[i].b == 32'd0) ? 2 : 33;
            do_div(v[i].s, v[i].a, v[i].b, rc, rn, sh, r, ra);
            checks++;
            if (rc !== lat) begin failures++; $display("FAIL dir_latency i=%0d got=%0d exp=%0d", i, rc, lat); end
            checks++;
            if (rn !== 1) begin failures++; $display("FAIL dir_ready_count i=%0d got=%0d exp=1", i, rn); end
            checks++;
            if (sh !== lat) begin failures++; $display("FAIL dir_stall_cycles i=%0d got=%0d exp=%0d", i, sh, lat); end
            checks++;
            if (r !== v[i].exp) begin failures++; $display("FAIL dir_result i=%0d got=%h exp=%h", i, r, v[i].exp); end
            checks++;
            if (ra !== v[i].exp) begin failures++; $display("FAIL dir_result_hold i=%0d got=%h exp=%h", i, ra, v[i].exp); end
            last_res = v[i].exp;
        end
    endtask

    task automatic test_random();
        int rc, rn, sh, lat;
        logic [63:0] r, ra, exp;
        logic s;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = $urandom;
                3: b = -$urandom_range(1, 300);
                4: b = a >> $urandom_range(0, 31);
                default: b = 32'hFFFFFFFF;
            endcase
            exp = ref_div(s, a, b);
            lat = (b == 32'd0) ? 2 : 33;
            do_div(s, a, b, rc, rn, sh, r, ra);
            checks++;
            if (rc !== lat) begin failures++; $display("FAIL rnd_latency i=%0d got=%0d exp=%0d", i, rc, lat); end
            checks++;
            if (rn !== 1) begin failures++; $display("FAIL rnd_ready_count i=%0d got=%0d exp=1", i, rn); end
            checks++;
            if (sh !== lat) begin failures++; $display("FAIL rnd_stall_cycles i=%0d got=%0d exp=%0d", i, sh, lat); end
            checks++;
            if (r !== exp) begin failures++; $display("FAIL rnd_result i=%0d s=%0d a=%h b=%h got=%h exp=%h", i, s, a, b, r, exp); end
            checks++;
            if (ra !== exp) begin failures++; $display("FAIL rnd_result_hold i=%0d got=%h exp=%h", i, ra, exp); end
            last_res = exp;
        end
    endtask

    task automatic test_annul();
        int rdy_seen, rc, rn, sh;
        logic [63:0] r, ra, exp;
        // abort while ON, then restart two cycles later
        rdy_seen = 0;
        bus.start = 1'b1; bus.signed_div = 1'b0; bus.a = 32'd1000; bus.b = 32'd3; bus.annul = 1'b0;
        for (int c = 0; c <= 11; c++) begin
            if (c == 10) begin bus.annul = 1'b1; bus.start = 1'b0; end
            if (c == 11) bus.annul = 1'b0;
            #1;
            if (bus.ready) rdy_seen++;
            if (c == 11) begin
                checks++;
                if (bus.stall_req !== 1'b0) begin failures++; $display("FAIL annul_on_idle got=%b exp=0", bus.stall_req); end
                checks++;
                if (bus.result !== last_res) begin failures++; $display("FAIL annul_on_result got=%h exp=%h", bus.result, last_res); end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (rdy_seen !== 0) begin failures++; $display("FAIL annul_on_ready got=%0d exp=0", rdy_seen); end
        exp = ref_div(1'b1, 32'hFFFF0000, 32'd13);
        do_div(1'b1, 32'hFFFF0000, 32'd13, rc, rn, sh, r, ra);
        checks++;
        if (rc !== 33) begin failures++; $display("FAIL annul_restart_latency got=%0d exp=33", rc); end
        checks++;
        if (r !== exp) begin failures++; $display("FAIL annul_restart_result got=%h exp=%h", r, exp); end
        last_res = exp;

        // abort exactly on the END cycle
        bus.start = 1'b1; bus.signed_div = 1'b0; bus.a = 32'd50; bus.b = 32'd5; bus.annul = 1'b0;
        for (int c = 0; c <= 34; c++) begin
            if (c == 33) bus.annul = 1'b1;
            if (c == 34) begin bus.annul = 1'b0; bus.start = 1'b0; end
            #1;
            if (c >= 33) begin
                checks++;
                if (bus.ready !== 1'b0) begin failures++; $display("FAIL annul_end_ready c=%0d got=%b exp=0", c, bus.ready); end
                checks++;
                if (bus.result !== last_res) begin failures++; $display("FAIL annul_end_result c=%0d got=%h exp=%h", c, bus.result, last_res); end
            end
            if (c == 34) begin
                checks++;
                if (bus.stall_req !== 1'b0) begin failures++; $display("FAIL annul_end_stall got=%b exp=0", bus.stall_req); end
            end
            @(posedge clk);
            #1;
        end

        // abort in DIVZ
        bus.start = 1'b1; bus.a = 32'd9; bus.b = 32'd0;
        for (int c = 0; c <= 3; c++) begin
            if (c == 1) begin bus.annul = 1'b1; bus.start = 1'b0; end
            if (c == 2) bus.annul = 1'b0;
            #1;
            if (c >= 2) begin
                checks++;
                if (bus.ready !== 1'b0) begin failures++; $display("FAIL annul_divz_ready c=%0d got=%b exp=0", c, bus.ready); end
                checks++;
                if (bus.result !== last_res) begin failures++; $display("FAIL annul_divz_result c=%0d got=%h exp=%h", c, bus.result, last_res); end
            end
            @(posedge clk);
            #1;
        end

        // annul in IDLE blocks acceptance
        bus.start = 1'b1; bus.annul = 1'b1; bus.a = 32'd9; bus.b = 32'd3;
        #1;
        checks++;
        if (bus.stall_req !== 1'b0) begin failures++; $display("FAIL annul_idle_stall got=%b exp=0", bus.stall_req); end
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.annul = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (bus.stall_req !== 1'b0 || bus.ready !== 1'b0) begin
                failures++;
                $display("FAIL annul_idle_after c=%0d got stall=%b ready=%b exp 0/0", c, bus.stall_req, bus.ready);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        int nr, c1, c2;
        logic [63:0] r1, r2, e1, e2;
        nr = 0; c1 = -1; c2 = -1; r1 = '0; r2 = '0;
        e1 = ref_div(1'b1, 32'hFFFFFF9C, 32'd7);
        e2 = ref_div(1'b0, 32'd12345, 32'd99);
        bus.annul = 1'b0; bus.start = 1'b1; bus.signed_div = 1'b1; bus.a = 32'hFFFFFF9C; bus.b = 32'd7;
        for (int c = 0; c <= 70; c++) begin
            #1;
            if (bus.ready) begin
                nr++;
                if (nr == 1) begin c1 = c; r1 = bus.result; end
                if (nr == 2) begin c2 = c; r2 = bus.result; end
            end
            @(posedge clk);
            #1;
            if (c == 32) begin bus.signed_div = 1'b0; bus.a = 32'd12345; bus.b = 32'd99; end
            if (nr >= 2) bus.start = 1'b0;
        end
        checks++;
        if (nr !== 2) begin failures++; $display("FAIL b2b_ready_count got=%0d exp=2", nr); end
        checks++;
        if (c1 !== 33) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=33", c1); end
        checks++;
        if (c2 !== 67) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=67", c2); end
        checks++;
        if (r1 !== e1) begin failures++; $display("FAIL b2b_first_result got=%h exp=%h", r1, e1); end
        checks++;
        if (r2 !== e2) begin failures++; $display("FAIL b2b_second_result got=%h exp=%h", r2, e2); end
        last_res = e2;
    endtask

    task automatic test_async_reset();
        bus.annul = 1'b0; bus.start = 1'b1; bus.signed_div = 1'b0; bus.a = 32'd77777; bus.b = 32'd5;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        bus.start = 1'b0;
        #1;
        checks++;
        if (bus.ready !== 1'b0) begin failures++; $display("FAIL arst_ready got=%b exp=0", bus.ready); end
        checks++;
        if (bus.stall_req !== 1'b0) begin failures++; $display("FAIL arst_stall got=%b exp=0", bus.stall_req); end
        checks++;
        if (bus.result !== 64'd0) begin failures++; $display("FAIL arst_result got=%h exp=0", bus.result); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.stall_req !== 1'b0 || bus.ready !== 1'b0) begin
                failures++;
                $display("FAIL arst_idle c=%0d got stall=%b ready=%b exp 0/0", c, bus.stall_req, bus.ready);
            end
        end
        last_res = 64'd0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        last_res = '0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.signed_div = 1'b0;
        bus.annul = 1'b0;
        bus.a = '0;
        bus.b = '0;
        test_reset();
        test_directed();
        test_random();
        test_annul();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
